vector_rotate_pipe: RTL and testbench
=====================================

Name: vector_rotate_pipe

Overview:
- Parametrised, stallable 2-stage fixed-point 2-D vector rotator. Computes ox = x·cos − y·sin and oy = x·sin + y·cos, with round-half-to-even.
- Sits between the sin/cos coefficient source and downstream sample consumers.
- Generalises the fixed s4.0 × s0.8 rotator to:
  - parametric widths;
  - valid/ready flow control;
  - per-sample inverse rotation;
  - a sideband tag that travels with each sample.

Parameters:
- IN_W, 5: signed input width, integer format sIN_W−1.0
- COEF_W, 9: signed coefficient width
- COEF_FRAC, 8: fractional bits of the coefficient; must be ≥1
- OUT_W, 6: signed output width, integer format
- TAG_W, 4: sideband tag width; must be ≥1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_x  in  IN_W  signed x
- in_y  in  IN_W  signed y
- in_cos  in  COEF_W  signed cos, sCOEF_W−COEF_FRAC−1.COEF_FRAC
- in_sin  in  COEF_W  signed sin, same format
- in_inv  in  1  1 = rotate by −θ (negate sin)
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready
- out_x  out  OUT_W  rotated x
- out_y  out  OUT_W  rotated y
- out_tag  out  TAG_W  tag of this sample
- out_sat  out  1  saturation occurred on x or y; constant 0 without the optional feature

Behaviour:
- Reset:
  - rst_n low asynchronously clears s1_valid and out_valid, and zeroes out_x, out_y, out_tag, out_sat and all stage-1 registers.
  - in_ready = 1 after reset.
  - Reset mid-stream drops all in-flight samples. No output appears until new input is accepted.
- Stage 1 (products):
  - Registers xc = x·cos, yc = y·cos, xs = x·s, ys = y·s, where s = in_inv ? −sin : sin.
  - Also registers the tag and s1_valid.
  - Each product is IN_W+COEF_W+1 bits, sign-extended, so negating the most negative sin cannot overflow.
- Stage 2 (sum, round, register):
  - qx = xc − ys and qy = xs + yc, each one bit wider than the products.
- Round-half-to-even, with F = COEF_FRAC:
  - i = q >>> F (arithmetic shift); r = q[F−1:0]; h = 1<<(F−1).
  - Result is i+1 if r>h, or if r==h and i[0]==1; otherwise i.
  - Rounding increment width is q's width; no intermediate overflow.
- Output width: the rounded value is reduced to OUT_W by truncation of upper bits (two's-complement wrap), unless the optional feature is enabled.
- Flow control:
  - s2_load = !out_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load (combinational).
  - On s2_load: out_* ← stage-2 result; out_valid ← s1_valid.
  - On s1_load: stage 1 ← input; s1_valid ← in_valid.
- Latency and throughput:
  - Latency is exactly 2 cycles from acceptance to out_valid when unstalled.
  - Throughput is 1 sample/clk.
- Stall rules:
  - While out_valid && !out_ready, out_* and out_valid hold stable.
  - Stage 1 holds if it is full.
  - At most 2 samples are in flight.
  - Strict order; no drop or duplicate.
- Simultaneous accept and drain at full occupancy: both stages advance in the same cycle, with no bubble.
- in_cos/in_sin/in_inv/in_tag are sampled only on acceptance. No check is made on cos²+sin²≈1.

Optional Feature:
- Macro: VECTOR_ROTATE_SAT_EN.
- Defined:
  - The rounded value clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1] per component.
  - out_sat = 1 for any output where either component clamped, registered with that output.
- Undefined:
  - Upper bits are truncated (wrap).
  - out_sat is tied to 0.
  - No clamp logic is synthesised.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 samples in flight → out_valid=0 and outputs 0 immediately. After release, in_ready=1 and no stale output appears.
- Basic: x=4, y=−3, cos=255, sin=0, inv=0, tag=5 → 2 cycles later out=(4,−3), tag=5, out_sat=0.
- Round-to-even: x=3, y=0, cos=128, sin=−128 → (2,−2). With x=1, y=0, cos=128, sin=128 → (0,0).
- Inverse: x=0, y=5, cos=0, sin=255 → inv=0 gives (−5,0); inv=1 gives (5,0).
- Backpressure: out_ready=0, offer 3 back-to-back samples tags 1,2,3 → only 1,2 accepted, in_ready=0 after. Raise out_ready → tags 1,2,3 emerge in order, 1/clk, with no drop or duplicate.
- Overflow: x=−16, y=−16, cos=−256, sin=−256 → oy raw 32. With SAT_EN: out_y=31, out_x=0, out_sat=1. Without: out_y=−32, out_sat=0.

Source files
------------

// File: rtl/vector_rotate_pipe.sv
// Stallable 2-stage fixed-point 2-D vector rotator with round-half-to-even and tag sideband.
// Optional output clamping and out_sat flag when VECTOR_ROTATE_SAT_EN is defined.
module vector_rotate_pipe #(
    parameter int IN_W      = 5,
    parameter int COEF_W    = 9,
    parameter int COEF_FRAC = 8,
    parameter int OUT_W     = 6,
    parameter int TAG_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_x,
    input  logic [IN_W-1:0]   in_y,
    input  logic [COEF_W-1:0] in_cos,
    input  logic [COEF_W-1:0] in_sin,
    input  logic              in_inv,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_x,
    output logic [OUT_W-1:0]  out_y,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_sat
);

    localparam int PW = IN_W + COEF_W + 1;
    localparam int QW = PW + 1;

    logic                 s1_valid_q;
    logic signed [PW-1:0] xc_q, yc_q, xs_q, ys_q;
    logic [TAG_W-1:0]     tag1_q;

    logic                 out_valid_q;
    logic [OUT_W-1:0]     out_x_q, out_y_q;
    logic [TAG_W-1:0]     out_tag_q;
    logic                 out_sat_q;

    logic                 s1_load, s2_load;
    logic signed [PW-1:0] x_e, y_e, c_e, s_e;
    logic signed [PW-1:0] xc_d, yc_d, xs_d, ys_d;
    logic signed [QW-1:0] qx, qy;
    logic [OUT_W-1:0]     out_x_d, out_y_d;
    logic                 out_sat_d;

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // sin is widened by one bit before negation so -(most negative) is representable
    always_comb begin
        x_e  = PW'($signed(in_x));
        y_e  = PW'($signed(in_y));
        c_e  = PW'($signed(in_cos));
        s_e  = in_inv ? -PW'($signed(in_sin)) : PW'($signed(in_sin));
        xc_d = x_e * c_e;
        yc_d = y_e * c_e;
        xs_d = x_e * s_e;
        ys_d = y_e * s_e;
    end

    function automatic logic signed [QW-1:0] rnd_even(input logic signed [QW-1:0] q);
        logic signed [QW-1:0]  i;
        logic [COEF_FRAC-1:0]  r;
        logic [COEF_FRAC-1:0]  h;
        i = q >>> COEF_FRAC;
        r = q[COEF_FRAC-1:0];
        h = COEF_FRAC'(1) << (COEF_FRAC - 1);
        if ((r > h) || ((r == h) && i[0]))
            i = i + QW'(1);
        return i;
    endfunction

    assign qx = QW'(xc_q) - QW'(ys_q);
    assign qy = QW'(xs_q) + QW'(yc_q);

`ifdef VECTOR_ROTATE_SAT_EN
    localparam logic signed [QW-1:0] MAXV = QW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [QW-1:0] MINV = -MAXV - QW'(1);

    logic signed [QW-1:0] rx, ry;
    logic                 sat_x, sat_y;

    always_comb begin
        rx      = rnd_even(qx);
        ry      = rnd_even(qy);
        sat_x   = 1'b0;
        sat_y   = 1'b0;
        out_x_d = OUT_W'(rx);
        out_y_d = OUT_W'(ry);
        if (rx > MAXV) begin
            out_x_d = OUT_W'(MAXV);
            sat_x   = 1'b1;
        end else if (rx < MINV) begin
            out_x_d = OUT_W'(MINV);
            sat_x   = 1'b1;
        end
        if (ry > MAXV) begin
            out_y_d = OUT_W'(MAXV);
            sat_y   = 1'b1;
        end else if (ry < MINV) begin
            out_y_d = OUT_W'(MINV);
            sat_y   = 1'b1;
        end
        out_sat_d = sat_x || sat_y;
    end
`else
    always_comb begin
        out_x_d   = OUT_W'(rnd_even(qx));
        out_y_d   = OUT_W'(rnd_even(qy));
        out_sat_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            xc_q       <= '0;
            yc_q       <= '0;
            xs_q       <= '0;
            ys_q       <= '0;
            tag1_q     <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            xc_q       <= xc_d;
            yc_q       <= yc_d;
            xs_q       <= xs_d;
            ys_q       <= ys_d;
            tag1_q     <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_tag_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_tag_q   <= tag1_q;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_tag   = out_tag_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_vector_rotate_pipe.sv
// Directed + random bench for vector_rotate_pipe with an expected-result queue.
module tb_vector_rotate_pipe;

    localparam int IN_W      = 5;
    localparam int COEF_W    = 9;
    localparam int COEF_FRAC = 8;
    localparam int OUT_W     = 6;
    localparam int TAG_W     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_x, in_y;
    logic [COEF_W-1:0] in_cos, in_sin;
    logic              in_inv;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_x, out_y;
    logic [TAG_W-1:0]  out_tag;
    logic              out_sat;

    vector_rotate_pipe #(
        .IN_W(IN_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .OUT_W(OUT_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_cos(in_cos), .in_sin(in_sin),
        .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_tag(out_tag), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] x;
        logic [OUT_W-1:0] y;
        logic [TAG_W-1:0] tag;
        logic             sat;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rnd_bp = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] ow(input int v);
        logic [31:0] t;
        t = v;
        return t[OUT_W-1:0];
    endfunction

    // floor division written out so it does not lean on shift semantics
    function automatic int round_even(input int q);
        int f, i, r;
        f = 1 << COEF_FRAC;
        i = (q >= 0) ? q / f : -((-q + f - 1) / f);
        r = q - i * f;
        if ((2 * r > f) || ((2 * r == f) && (i % 2 != 0)))
            i = i + 1;
        return i;
    endfunction

    function automatic exp_t model(input int x, y, c, s, input bit inv, input logic [TAG_W-1:0] tag);
        exp_t e;
        int sv, rx, ry, hi, lo;
        bit sat;
        sv  = inv ? -s : s;
        rx  = round_even(x * c - y * sv);
        ry  = round_even(x * sv + y * c);
        hi  = (1 << (OUT_W - 1)) - 1;
        lo  = -(1 << (OUT_W - 1));
        sat = 1'b0;
`ifdef VECTOR_ROTATE_SAT_EN
        if (rx > hi) begin rx = hi; sat = 1'b1; end
        if (rx < lo) begin rx = lo; sat = 1'b1; end
        if (ry > hi) begin ry = hi; sat = 1'b1; end
        if (ry < lo) begin ry = lo; sat = 1'b1; end
`endif
        e.x   = ow(rx);
        e.y   = ow(ry);
        e.tag = tag;
        e.sat = sat;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                sbq.push_back(model(int'($signed(in_x)), int'($signed(in_y)),
                                    int'($signed(in_cos)), int'($signed(in_sin)), in_inv, in_tag));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("out_x",   32'(out_x),   32'(e.x));
                    check("out_y",   32'(out_y),   32'(e.y));
                    check("out_tag", 32'(out_tag), 32'(e.tag));
                    check("out_sat", 32'(out_sat), 32'(e.sat));
                end
            end
        end
    end

    task automatic set_in(input int x, y, c, s, input bit inv, input int tag);
        in_x     = IN_W'(x);
        in_y     = IN_W'(y);
        in_cos   = COEF_W'(c);
        in_sin   = COEF_W'(s);
        in_inv   = inv;
        in_tag   = TAG_W'(tag);
        in_valid = 1'b1;
    endtask

    task automatic send(input int x, y, c, s, input bit inv, input int tag);
        bit acc;
        acc = 1'b0;
        set_in(x, y, c, s, inv, tag);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (sbq.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_x = '0; in_y = '0; in_cos = '0; in_sin = '0; in_inv = 1'b0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_x",     32'(out_x),     32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        check("rst_out_sat",   32'(out_sat),   32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;

        // basic rotation and latency
        send(4, -3, 255, 0, 0, 5);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("basic_x",   32'(out_x),     32'(ow(4)));
        check("basic_y",   32'(out_y),     32'(ow(-3)));
        check("basic_tag", 32'(out_tag),   32'd5);
        drain();

        // ties, inverse rotation
        send(3, 0, 128, -128, 0, 6);
        send(1, 0, 128, 128, 0, 7);
        send(0, 5, 0, 255, 0, 8);
        send(0, 5, 0, 255, 1, 9);
        drain();

        // overflow of the y component
        send(-16, -16, -256, -256, 0, 10);
        @(posedge clk);
        #1;
        check("ovf_x", 32'(out_x), 32'(ow(0)));
`ifdef VECTOR_ROTATE_SAT_EN
        check("ovf_y",   32'(out_y),   32'(ow(31)));
        check("ovf_sat", 32'(out_sat), 32'd1);
`else
        check("ovf_y",   32'(out_y),   32'(ow(-32)));
        check("ovf_sat", 32'(out_sat), 32'd0);
`endif
        drain();

        // backpressure: only two samples fit
        out_ready = 1'b0;
        send(1, 2, 100, 50, 0, 1);
        send(-2, 3, -60, 200, 1, 2);
        set_in(7, -8, 30, -90, 0, 3);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_tag",   32'(out_tag),   32'd1);
        check("bp_in_ready2",  32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_t1", 32'(out_tag), 32'd1);
        check("bp_acc3", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_v2", 32'(out_valid), 32'd1);
        check("bp_t2", 32'(out_tag),   32'd2);
        @(negedge clk);
        check("bp_v3", 32'(out_valid), 32'd1);
        check("bp_t3", 32'(out_tag),   32'd3);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        drain();

        // random traffic with random backpressure
        rnd_bp = 1;
        for (int n = 0; n < 40; n++)
            send(int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
                 int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                 1'($urandom_range(0, 1)), n % 16);
        rnd_bp = 0;
        out_ready = 1'b1;
        drain();

        // reset with two samples in flight
        send(2, 2, 200, 100, 0, 11);
        send(-3, 1, 150, -150, 0, 12);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_x",     32'(out_x),     32'd0);
        check("mid_rst_y",     32'(out_y),     32'd0);
        check("mid_rst_tag",   32'(out_tag),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(4, -3, 255, 0, 0, 13);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
